// File: rtl/eq_pkg.sv
// Shared constants for the multichannel biquad equaliser.
// Defaults, FSM encoding, MAC tap order and Q-format constants.
package eq_pkg;

    localparam int DW_DEF   = 24;
    localparam int CW_DEF   = 18;
    localparam int NCH_DEF  = 2;
    localparam int NSEC_DEF = 3;

    // Coefficients are Q2.(CW-2): section outputs shift by CW-QFMT_INT.
    localparam int QFMT_INT = 2;
    // The ROM table is written in Q2.16 and rescaled to CW.
    localparam int TBL_FRAC = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WB,
        S_OUT
    } state_t;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;

endpackage

// File: rtl/eq_coef_rom.sv
// Coefficient ROM, addressed by {bank, section, tap}, registered output.
// Ports: i_clk, i_bank, i_sec, i_tap -> o_coef (one cycle later).
module eq_coef_rom
    import eq_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int SW = 2
) (
    input  logic                 i_clk,
    input  logic [2:0]           i_bank,
    input  logic [SW-1:0]        i_sec,
    input  logic [2:0]           i_tap,
    output logic signed [CW-1:0] o_coef
);

    // Table in Q2.16; banks 0, 4, 6 are bypass (b0 = 1.0).
    // Bank 7 scales section 0 by 1.5 and bypasses the rest.
    function automatic int tbl(
        input logic [2:0] bank,
        input logic       sec0,
        input logic [2:0] tap
    );
        int b0, b1, b2, a1, a2;
        b0 = 65536;
        b1 = 0;
        b2 = 0;
        a1 = 0;
        a2 = 0;
        case (bank)
            3'd1: begin
                b0 = 16384; b1 = 32768; b2 = 16384;
                a1 = -32768; a2 = 8192;
            end
            3'd2: begin
                b0 = 65536; b1 = -65536;
                a1 = -58982;
            end
            3'd3: begin
                b0 = 8192; b1 = 16384; b2 = 8192;
                a1 = -78643; a2 = 29491;
            end
            3'd5: begin
                b0 = 72089; b1 = -98304; b2 = 45875;
                a1 = -98304; a2 = 39322;
            end
            3'd7: begin
                if (sec0) b0 = 98304;
            end
            default: ;
        endcase
        case (tap)
            TAP_B0:  return b0;
            TAP_B1:  return b1;
            TAP_B2:  return b2;
            TAP_A1:  return a1;
            TAP_A2:  return a2;
            default: return 0;
        endcase
    endfunction

    longint                w_wide;
    logic signed [CW-1:0]  r_coef;

    always_comb begin
        w_wide = longint'(tbl(i_bank, i_sec == '0, i_tap));
        w_wide = (w_wide <<< CW) >>> (TBL_FRAC + QFMT_INT);
    end

    always_ff @(posedge i_clk) begin
        r_coef <= w_wide[CW-1:0];
    end

    assign o_coef = r_coef;

endmodule

// File: rtl/eq_biquad_mc.sv
// Multichannel cascaded DF-I biquad EQ on one time-shared MAC.
// Ports: sys_clk/sys_rst, din_vld/din/coe_ctrl in, dout/dout_vld/busy/overrun out.
module eq_biquad_mc
    import eq_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int NCH  = NCH_DEF,
    parameter int NSEC = NSEC_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              din_vld,
    input  logic [NCH*DW-1:0] din,
    input  logic [2:0]        coe_ctrl,
    output logic [NCH*DW-1:0] dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              overrun
);

    localparam int AW  = DW + CW + 4;
    localparam int QS  = CW - QFMT_INT;
    localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic signed [AW-1:0] RND =
        {{(AW-1){1'b0}}, 1'b1} << (QS - 1);
    localparam logic signed [AW-1:0] YMAX =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] YMIN =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                  r_state;
    state_t                  w_next;
    logic [2:0]              r_tap;
    logic [SW-1:0]           r_sec;
    logic [CHW-1:0]          r_ch;
    logic [2:0]              r_bank;
    logic [2:0]              r_last_bank;
    logic [NCH*DW-1:0]       r_din;
    logic signed [DW-1:0]    r_xin;
    logic signed [AW-1:0]    r_acc;
    logic [NCH*DW-1:0]       r_stage;
    logic [NCH*DW-1:0]       r_dout;
    logic                    r_dout_vld;
    logic                    r_overrun;

    logic signed [DW-1:0]    r_x1 [NCH][NSEC];
    logic signed [DW-1:0]    r_x2 [NCH][NSEC];
    logic signed [DW-1:0]    r_y1 [NCH][NSEC];
    logic signed [DW-1:0]    r_y2 [NCH][NSEC];

    logic                    w_busy;
    logic                    w_accept;
    logic                    w_last_sec;
    logic                    w_last_ch;
    logic [2:0]              w_ptap;
    logic signed [CW-1:0]    w_coef;
    logic signed [DW-1:0]    w_opnd;
    logic signed [DW+CW-1:0] w_prod;
    logic signed [AW-1:0]    w_pext;
    logic                    w_sub;
    logic signed [AW-1:0]    w_sum;
    logic signed [AW-1:0]    w_rnd;
    logic signed [AW-1:0]    w_sh;
    logic signed [DW-1:0]    w_y;
    logic signed [DW-1:0]    w_nxt_x;

    eq_coef_rom #(
        .CW (CW),
        .SW (SW)
    ) u_rom (
        .i_clk  (sys_clk),
        .i_bank (r_bank),
        .i_sec  (r_sec),
        .i_tap  (r_tap),
        .o_coef (w_coef)
    );

    // busy covers the dout_vld cycle, so a strobe there is dropped.
    assign w_busy     = (r_state != S_IDLE) || r_dout_vld;
    assign w_accept   = din_vld && !w_busy;
    assign w_last_sec = (r_sec == SW'(NSEC - 1));
    assign w_last_ch  = (r_ch == CHW'(NCH - 1));

    // ROM output lags the address by one cycle, so the product in
    // flight belongs to the previous tap; WB consumes the a2 term.
    assign w_ptap = (r_state == S_WB) ? TAP_A2 : r_tap - 3'd1;

    always_comb begin
        w_opnd = '0;
        case (w_ptap)
            TAP_B0:  w_opnd = r_xin;
            TAP_B1:  w_opnd = r_x1[r_ch][r_sec];
            TAP_B2:  w_opnd = r_x2[r_ch][r_sec];
            TAP_A1:  w_opnd = r_y1[r_ch][r_sec];
            TAP_A2:  w_opnd = r_y2[r_ch][r_sec];
            default: w_opnd = '0;
        endcase
    end

    assign w_prod = w_opnd * w_coef;
    assign w_pext = {{(AW-DW-CW){w_prod[DW+CW-1]}}, w_prod};
    assign w_sub  = (w_ptap == TAP_A1) || (w_ptap == TAP_A2);
    assign w_sum  = w_sub ? r_acc - w_pext : r_acc + w_pext;

    always_comb begin
        w_rnd = w_sum + RND;
        w_sh  = w_rnd >>> QS;
        if (w_sh > YMAX) begin
            w_y = YMAX[DW-1:0];
        end else if (w_sh < YMIN) begin
            w_y = YMIN[DW-1:0];
        end else begin
            w_y = w_sh[DW-1:0];
        end
    end

    always_comb begin
        w_nxt_x = '0;
        for (int c = 0; c < NCH; c++) begin
            if (c == int'(r_ch) + 1) w_nxt_x = r_din[c*DW +: DW];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_MAC;
            S_MAC:   if (r_tap == TAP_A2) w_next = S_WB;
            S_WB:    w_next = (w_last_sec && w_last_ch) ? S_OUT : S_MAC;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= S_IDLE;
            r_tap       <= '0;
            r_sec       <= '0;
            r_ch        <= '0;
            r_bank      <= '0;
            r_last_bank <= '0;
            r_din       <= '0;
            r_xin       <= '0;
            r_acc       <= '0;
            r_stage     <= '0;
            r_dout      <= '0;
            r_dout_vld  <= 1'b0;
            r_overrun   <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                for (int s = 0; s < NSEC; s++) begin
                    r_x1[c][s] <= '0;
                    r_x2[c][s] <= '0;
                    r_y1[c][s] <= '0;
                    r_y2[c][s] <= '0;
                end
            end
        end else begin
            r_state    <= w_next;
            r_dout_vld <= 1'b0;
            if (din_vld && w_busy) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bank      <= coe_ctrl;
                        r_last_bank <= coe_ctrl;
                        r_din       <= din;
                        r_xin       <= din[DW-1:0];
                        r_tap       <= '0;
                        r_sec       <= '0;
                        r_ch        <= '0;
                        // Old state is meaningless under new coefficients.
                        if (coe_ctrl != r_last_bank) begin
                            for (int c = 0; c < NCH; c++) begin
                                for (int s = 0; s < NSEC; s++) begin
                                    r_x1[c][s] <= '0;
                                    r_x2[c][s] <= '0;
                                    r_y1[c][s] <= '0;
                                    r_y2[c][s] <= '0;
                                end
                            end
                        end
                    end
                end
                S_MAC: begin
                    r_tap <= r_tap + 3'd1;
                    r_acc <= (r_tap == TAP_B0) ? '0 : w_sum;
                end
                S_WB: begin
                    r_x2[r_ch][r_sec] <= r_x1[r_ch][r_sec];
                    r_x1[r_ch][r_sec] <= r_xin;
                    r_y2[r_ch][r_sec] <= r_y1[r_ch][r_sec];
                    r_y1[r_ch][r_sec] <= w_y;
                    r_tap <= '0;
                    if (w_last_sec) begin
                        for (int c = 0; c < NCH; c++) begin
                            if (r_ch == CHW'(c)) r_stage[c*DW +: DW] <= w_y;
                        end
                        r_sec <= '0;
                        r_ch  <= r_ch + 1'b1;
                        r_xin <= w_nxt_x;
                    end else begin
                        r_sec <= r_sec + 1'b1;
                        r_xin <= w_y;
                    end
                end
                S_OUT: begin
                    r_dout     <= r_stage;
                    r_dout_vld <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign busy     = w_busy;
    assign overrun  = r_overrun;

endmodule
